// File: rtl/cpu_types_pkg.sv
// Shared CPU types: branch opcodes, 2-bit predictor counter and BTB entry layout.
package cpu_types_pkg;

    localparam logic [5:0] BEQ = 6'b000100;
    localparam logic [5:0] BNE = 6'b000101;

    typedef enum logic [1:0] {
        SNT = 2'b00,
        WNT = 2'b01,
        WT  = 2'b10,
        ST  = 2'b11
    } ctr2_t;

    // Tag is stored right-aligned in 32 bits so the layout does not depend on ENTRIES.
    typedef struct packed {
        logic        valid;
        logic [31:0] tag;
        logic [31:0] target;
        ctr2_t       ctr;
    } btb_entry_t;

    function automatic logic [31:0] sat_inc32(input logic [31:0] x);
        return (x == 32'hFFFF_FFFF) ? x : x + 32'd1;
    endfunction

endpackage

// File: rtl/sat_counter2.sv
// Next-state function of a 2-bit saturating taken/not-taken counter.
module sat_counter2
    import cpu_types_pkg::*;
(
    input  ctr2_t cur,
    input  logic  taken,
    output ctr2_t next
);

    // Step toward ST on taken, toward SNT on not-taken, holding at the ends.
    always_comb begin
        next = cur;
        if (taken && cur != ST)
            next = ctr2_t'(cur + 2'd1);
        else if (!taken && cur != SNT)
            next = ctr2_t'(cur - 2'd1);
    end

endmodule

// File: rtl/branch_target_predictor.sv
// Direct-mapped BTB with 2-bit counters: IF-stage prediction, MEM-stage
// resolution/retraining and saturating performance counters.
module branch_target_predictor
    import cpu_types_pkg::*;
#(
    parameter int ENTRIES = 16,
    parameter int IDX_W   = $clog2(ENTRIES)
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic [31:0] pc_if,
    input  logic [31:0] instruction_if,
    input  logic        stop_new_branch,
    output logic        predict_taken,
    output logic [31:0] predict_target,
    input  logic        branch_valid_mem,
    input  logic        update_en,
    input  logic [31:0] pc_mem,
    input  logic [31:0] target_mem,
    input  logic        taken_mem,
    input  logic        predicted_mem,
    input  logic [31:0] predicted_target_mem,
    output logic        branch_taken,
    output logic        branch_prediction,
    output logic        mispredict,
    output logic [31:0] recovery_pc,
    output logic [31:0] branch_count,
    output logic [31:0] mispredict_count
);

    btb_entry_t btb [ENTRIES];

    logic [IDX_W-1:0] if_idx, up_idx;
    logic [31:0]      if_tag, up_tag;
    logic             is_branch, if_hit, up_hit, target_err, do_update;
    ctr2_t            ctr_next;

    // Opcode-only predecode; the rest of the fetched word is irrelevant here.
    logic unused_insn_bits;
    assign unused_insn_bits = ^instruction_if[25:0];

    assign if_idx = pc_if[IDX_W+1:2];
    assign if_tag = {{(IDX_W+2){1'b0}}, pc_if[31:IDX_W+2]};
    assign up_idx = pc_mem[IDX_W+1:2];
    assign up_tag = {{(IDX_W+2){1'b0}}, pc_mem[31:IDX_W+2]};

    assign is_branch = (instruction_if[31:26] == BEQ) || (instruction_if[31:26] == BNE);
    assign if_hit    = btb[if_idx].valid && (btb[if_idx].tag == if_tag);
    assign up_hit    = btb[up_idx].valid && (btb[up_idx].tag == up_tag);
    assign do_update = branch_valid_mem && update_en;

    // Lookup reads registered state only, so a same-cycle update is not bypassed.
    always_comb begin
        predict_taken  = is_branch && if_hit && btb[if_idx].ctr[1] && !stop_new_branch;
        predict_target = predict_taken ? btb[if_idx].target : pc_if + 32'd4;
    end

    // Resolution: direction error, or correct taken guess with the wrong target.
    always_comb begin
        target_err        = taken_mem && predicted_mem && (predicted_target_mem != target_mem);
        mispredict        = branch_valid_mem && ((taken_mem != predicted_mem) || target_err);
        recovery_pc       = taken_mem ? target_mem : pc_mem + 32'd4;
        branch_taken      = taken_mem && branch_valid_mem;
        // A target-only error still had the direction right, so report it as such.
        branch_prediction = target_err ? branch_taken : (predicted_mem && branch_valid_mem);
    end

    sat_counter2 u_ctr (
        .cur   (btb[up_idx].ctr),
        .taken (taken_mem),
        .next  (ctr_next)
    );

    // Table retraining and statistics; reset overrides any same-cycle update.
    always_ff @(posedge CLK) begin
        if (RST) begin
            for (int i = 0; i < ENTRIES; i++)
                btb[i] <= '{valid: 1'b0, tag: 32'd0, target: 32'd0, ctr: WNT};
            branch_count     <= 32'd0;
            mispredict_count <= 32'd0;
        end else if (do_update) begin
            branch_count <= sat_inc32(branch_count);
            if (mispredict)
                mispredict_count <= sat_inc32(mispredict_count);
            if (up_hit) begin
                btb[up_idx].ctr <= ctr_next;
                if (taken_mem)
                    btb[up_idx].target <= target_mem;
            end else if (taken_mem) begin
                btb[up_idx] <= '{valid: 1'b1, tag: up_tag, target: target_mem, ctr: WT};
            end
        end
    end

endmodule

// File: tb/tb_branch_target_predictor.sv
// Directed bench with a per-cycle reference model of the BTB predictor.
module tb_branch_target_predictor;

    logic        CLK = 1'b0;
    logic        RST;
    logic [31:0] pc_if, instruction_if;
    logic        stop_new_branch;
    logic        predict_taken;
    logic [31:0] predict_target;
    logic        branch_valid_mem, update_en;
    logic [31:0] pc_mem, target_mem;
    logic        taken_mem, predicted_mem;
    logic [31:0] predicted_target_mem;
    logic        branch_taken, branch_prediction, mispredict;
    logic [31:0] recovery_pc, branch_count, mispredict_count;

    int errors = 0;
    int checks = 0;
    bit chk_en = 0;

    branch_target_predictor #(.ENTRIES(16)) dut (
        .CLK(CLK), .RST(RST), .pc_if(pc_if), .instruction_if(instruction_if),
        .stop_new_branch(stop_new_branch), .predict_taken(predict_taken),
        .predict_target(predict_target), .branch_valid_mem(branch_valid_mem),
        .update_en(update_en), .pc_mem(pc_mem), .target_mem(target_mem),
        .taken_mem(taken_mem), .predicted_mem(predicted_mem),
        .predicted_target_mem(predicted_target_mem), .branch_taken(branch_taken),
        .branch_prediction(branch_prediction), .mispredict(mispredict),
        .recovery_pc(recovery_pc), .branch_count(branch_count),
        .mispredict_count(mispredict_count)
    );

    always #5 CLK = ~CLK;

    // ---------------- reference model ----------------
    bit          m_valid [16];
    longint      m_tag   [16];
    logic [31:0] m_tgt   [16];
    int          m_ctr   [16];
    logic [31:0] m_bc, m_mc;

    function automatic int idx_of(input logic [31:0] pc);
        return int'((pc / 4) % 16);
    endfunction

    function automatic longint tag_of(input logic [31:0] pc);
        return longint'(pc / 64);
    endfunction

    function automatic bit m_pred_taken();
        int i;
        bit br;
        i  = idx_of(pc_if);
        br = (instruction_if[31:26] == 6'd4) || (instruction_if[31:26] == 6'd5);
        return br && m_valid[i] && (m_tag[i] == tag_of(pc_if)) && (m_ctr[i] >= 2) && !stop_new_branch;
    endfunction

    function automatic bit m_tgt_err();
        return taken_mem && predicted_mem && (predicted_target_mem != target_mem);
    endfunction

    function automatic bit m_misp();
        return branch_valid_mem && ((taken_mem != predicted_mem) || m_tgt_err());
    endfunction

    always @(posedge CLK) begin
        if (RST) begin
            for (int i = 0; i < 16; i++) begin
                m_valid[i] = 0; m_tag[i] = 0; m_tgt[i] = 0; m_ctr[i] = 1;
            end
            m_bc = 0; m_mc = 0;
        end else if (branch_valid_mem && update_en) begin
            int i;
            i = idx_of(pc_mem);
            if (m_misp() && m_mc != 32'hFFFF_FFFF) m_mc = m_mc + 1;
            if (m_bc != 32'hFFFF_FFFF) m_bc = m_bc + 1;
            if (m_valid[i] && m_tag[i] == tag_of(pc_mem)) begin
                if (taken_mem) begin
                    m_ctr[i] = (m_ctr[i] == 3) ? 3 : m_ctr[i] + 1;
                    m_tgt[i] = target_mem;
                end else begin
                    m_ctr[i] = (m_ctr[i] == 0) ? 0 : m_ctr[i] - 1;
                end
            end else if (taken_mem) begin
                m_valid[i] = 1; m_tag[i] = tag_of(pc_mem); m_tgt[i] = target_mem; m_ctr[i] = 2;
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Compare every output against the model on the falling edge.
    always @(negedge CLK) begin
        if (chk_en) begin
            bit pt;
            pt = m_pred_taken();
            chk("m.predict_taken", {31'd0, predict_taken}, {31'd0, pt});
            chk("m.predict_target", predict_target, pt ? m_tgt[idx_of(pc_if)] : pc_if + 32'd4);
            chk("m.mispredict", {31'd0, mispredict}, {31'd0, m_misp()});
            if (m_misp())
                chk("m.recovery_pc", recovery_pc, taken_mem ? target_mem : pc_mem + 32'd4);
            chk("m.branch_taken", {31'd0, branch_taken}, {31'd0, taken_mem & branch_valid_mem});
            chk("m.branch_prediction", {31'd0, branch_prediction},
                {31'd0, branch_valid_mem & (m_tgt_err() ? taken_mem : predicted_mem)});
            chk("m.branch_count", branch_count, m_bc);
            chk("m.mispredict_count", mispredict_count, m_mc);
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic cyc();
        @(posedge CLK); #1;
    endtask

    task automatic set_if(input logic [31:0] pc, input bit br);
        pc_if = pc;
        instruction_if = br ? {6'd4, 26'h0123} : 32'h2000_0000;
    endtask

    task automatic set_mem(input bit v, input bit en, input logic [31:0] pc, input logic [31:0] tgt,
                           input bit tk, input bit pr, input logic [31:0] ptgt);
        branch_valid_mem = v; update_en = en; pc_mem = pc; target_mem = tgt;
        taken_mem = tk; predicted_mem = pr; predicted_target_mem = ptgt;
    endtask

    task automatic mem_idle();
        set_mem(0, 0, 32'h0, 32'h0, 0, 0, 32'h0);
    endtask

    // One resolved branch at 0x40 that then gets retired; checks IF prediction afterwards.
    task automatic resolve40(input bit tk, input bit pr, input bit exp_pred_after);
        set_mem(1, 1, 32'h40, 32'h80, tk, pr, 32'h80);
        cyc();
        mem_idle(); #1;
        chk("seq.predict_taken", {31'd0, predict_taken}, {31'd0, exp_pred_after});
    endtask

    initial begin
        RST = 1; stop_new_branch = 0;
        set_if(32'h40, 1); mem_idle();
        cyc(); cyc();
        chk_en = 1;
        cyc();
        RST = 0; #1;

        // Reset state.
        chk("rst.predict_taken", {31'd0, predict_taken}, 32'd0);
        chk("rst.predict_target", predict_target, 32'h44);
        chk("rst.branch_count", branch_count, 32'd0);
        chk("rst.mispredict_count", mispredict_count, 32'd0);
        chk("rst.mispredict", {31'd0, mispredict}, 32'd0);
        chk("rst.branch_prediction", {31'd0, branch_prediction}, 32'd0);

        // First taken resolution allocates the entry (ctr=10).
        set_mem(1, 1, 32'h40, 32'h80, 1, 0, 32'h44); #1;
        chk("alloc.mispredict", {31'd0, mispredict}, 32'd1);
        chk("alloc.recovery_pc", recovery_pc, 32'h80);
        chk("alloc.branch_taken", {31'd0, branch_taken}, 32'd1);
        chk("alloc.branch_prediction", {31'd0, branch_prediction}, 32'd0);
        cyc(); mem_idle(); #1;
        chk("alloc.predict_taken", {31'd0, predict_taken}, 32'd1);
        chk("alloc.predict_target", predict_target, 32'h80);
        chk("alloc.branch_count", branch_count, 32'd1);
        chk("alloc.mispredict_count", mispredict_count, 32'd1);

        // ctr 10 -> 11 -> 11 -> 10 -> 01 -> 00.
        resolve40(1, 1, 1);
        resolve40(1, 1, 1);
        resolve40(0, 1, 1);
        resolve40(0, 1, 0);
        resolve40(0, 0, 0);
        chk("train.mispredict_count", mispredict_count, 32'd3);

        // Same-index update and lookup: IF sees the pre-update counter.
        set_if(32'h48, 1);
        set_mem(1, 1, 32'h48, 32'h100, 1, 0, 32'h4C);
        cyc();
        set_mem(1, 1, 32'h48, 32'h100, 0, 1, 32'h100); #1;
        chk("coll.old_predict", {31'd0, predict_taken}, 32'd1);
        chk("coll.old_target", predict_target, 32'h100);
        cyc(); mem_idle(); #1;
        chk("coll.new_predict", {31'd0, predict_taken}, 32'd0);

        // Stall: mispredict evaluates but nothing changes.
        set_mem(1, 0, 32'h48, 32'h200, 1, 0, 32'h4C); #1;
        chk("stall.mispredict", {31'd0, mispredict}, 32'd1);
        chk("stall.recovery_pc", recovery_pc, 32'h200);
        cyc(); cyc();
        chk("stall.branch_count", branch_count, 32'd8);
        chk("stall.predict_taken", {31'd0, predict_taken}, 32'd0);
        mem_idle();

        // Aliasing: 0x80 shares index 0 with 0x40 and replaces it.
        set_mem(1, 1, 32'h80, 32'hC0, 1, 0, 32'h84);
        cyc(); mem_idle();
        set_if(32'h40, 1); #1;
        chk("alias.predict_taken", {31'd0, predict_taken}, 32'd0);
        chk("alias.predict_target", predict_target, 32'h44);
        set_if(32'h80, 1); #1;
        chk("alias.hit_target", predict_target, 32'hC0);

        // Target-only error: direction reported as correct, still a redirect.
        set_mem(1, 1, 32'h80, 32'hD0, 1, 1, 32'hC0); #1;
        chk("tgt.mispredict", {31'd0, mispredict}, 32'd1);
        chk("tgt.branch_prediction", {31'd0, branch_prediction}, 32'd1);
        cyc(); mem_idle(); #1;
        chk("tgt.new_target", predict_target, 32'hD0);

        // stop_new_branch and non-branch opcodes suppress the prediction.
        stop_new_branch = 1; #1;
        chk("stop.predict_taken", {31'd0, predict_taken}, 32'd0);
        chk("stop.predict_target", predict_target, 32'h84);
        stop_new_branch = 0;
        set_if(32'h80, 0); #1;
        chk("nonbr.predict_taken", {31'd0, predict_taken}, 32'd0);
        cyc();

        // PC wraparound on both sides; not-taken miss writes nothing.
        set_if(32'hFFFF_FFFC, 1);
        set_mem(1, 1, 32'hFFFF_FFFC, 32'h10, 0, 1, 32'h10); #1;
        chk("wrap.predict_target", predict_target, 32'h0);
        chk("wrap.recovery_pc", recovery_pc, 32'h0);
        cyc(); mem_idle(); #1;
        chk("wrap.no_alloc", {31'd0, predict_taken}, 32'd0);

        // Reset during a taken update: the write is discarded.
        set_if(32'h40, 1);
        RST = 1;
        set_mem(1, 1, 32'h40, 32'h80, 1, 0, 32'h44);
        cyc();
        RST = 0; mem_idle(); #1;
        chk("rstmid.predict_taken", {31'd0, predict_taken}, 32'd0);
        chk("rstmid.branch_count", branch_count, 32'd0);
        chk("rstmid.mispredict_count", mispredict_count, 32'd0);

        // Counter saturation at all-ones.
        force dut.mispredict_count = 32'hFFFF_FFFF;
        force dut.branch_count = 32'hFFFF_FFFF;
        #1;
        release dut.mispredict_count;
        release dut.branch_count;
        m_mc = 32'hFFFF_FFFF; m_bc = 32'hFFFF_FFFF;
        set_mem(1, 1, 32'h40, 32'h80, 1, 0, 32'h44);
        cyc(); mem_idle(); #1;
        chk("sat.mispredict_count", mispredict_count, 32'hFFFF_FFFF);
        chk("sat.branch_count", branch_count, 32'hFFFF_FFFF);
        cyc(); cyc();

        chk_en = 0;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1);
    end

endmodule
